// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the magnitude comparators: FSM states, default width and
// the lesser/greater/equal verdict triple.
package cmp_pkg;

  typedef enum logic {
    COLLECT,
    RESULT
  } state_t;

  localparam int unsigned CMP_N = 16;

  typedef struct packed {
    logic lesser;
    logic greater;
    logic equal;
  } cmp_result_t;

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Beat stream in, verdict stream out, for the bit-serial magnitude comparator.
interface serial_magnitude_comparator_if #(
  parameter int unsigned N = 16
);
  localparam int unsigned CW = $clog2(N + 1);

  logic          in_valid;
  logic          in_ready;
  logic          a_bit;
  logic          b_bit;
  logic          in_last;
  logic          res_valid;
  logic          res_ready;
  logic          lesser;
  logic          greater;
  logic          equal;
  logic          len_err;
  logic [CW-1:0] bit_count;

  modport master (
    output in_valid, a_bit, b_bit, in_last, res_ready,
    input  in_ready, res_valid, lesser, greater, equal, len_err, bit_count
  );

  modport slave (
    input  in_valid, a_bit, b_bit, in_last, res_ready,
    output in_ready, res_valid, lesser, greater, equal, len_err, bit_count
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: operands arrive MSB first, one bit
// pair per beat; the first differing pair decides the verdict for the frame.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned N = CMP_N
) (
  input logic                          clk,
  input logic                          rst,
  serial_magnitude_comparator_if.slave bus
);
  localparam int unsigned CW = $clog2(N + 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_inc, bit_count_q;
  logic          decided, gt, decided_nx, gt_nx;
  logic          accept, frame_end, len_err_q;
  cmp_result_t   res_q, res_nx;

  always_comb begin
    accept     = bus.in_valid && (state == COLLECT);
    cnt_inc    = cnt + CW'(1);
    frame_end  = accept && (bus.in_last || (cnt_inc == CW'(N)));
    decided_nx = decided | (bus.a_bit ^ bus.b_bit);
    gt_nx      = (!decided && (bus.a_bit != bus.b_bit)) ? bus.a_bit : gt;
    res_nx.lesser  = decided_nx & ~gt_nx;
    res_nx.greater = decided_nx & gt_nx;
    res_nx.equal   = ~decided_nx;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (frame_end) state_next = RESULT;
      RESULT:  if (bus.res_ready) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      decided     <= 1'b0;
      gt          <= 1'b0;
      res_q       <= '0;
      len_err_q   <= 1'b0;
      bit_count_q <= '0;
    end else if (frame_end) begin
      // Verdict includes the closing beat itself; tracking state restarts for the next frame.
      res_q       <= res_nx;
      bit_count_q <= cnt_inc;
      len_err_q   <= !(bus.in_last && (cnt_inc == CW'(N)));
      cnt         <= '0;
      decided     <= 1'b0;
      gt          <= 1'b0;
    end else if (accept) begin
      cnt     <= cnt_inc;
      decided <= decided_nx;
      gt      <= gt_nx;
    end else if (state == RESULT && bus.res_ready) begin
      res_q       <= '0;
      len_err_q   <= 1'b0;
      bit_count_q <= '0;
    end
  end

  assign bus.in_ready  = (state == COLLECT);
  assign bus.res_valid = (state == RESULT);
  assign bus.lesser    = res_q.lesser;
  assign bus.greater   = res_q.greater;
  assign bus.equal     = res_q.equal;
  assign bus.len_err   = len_err_q;
  assign bus.bit_count = bit_count_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Randomised and directed bench for serial_magnitude_comparator, checked every
// cycle against an integer-arithmetic model of each frame.
module tb_serial_magnitude_comparator;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rr_rand = 1'b0;

  int checks = 0;
  int errors = 0;

  serial_magnitude_comparator_if #(.N(N)) bus ();

  serial_magnitude_comparator #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: accumulate each operand as an integer, compare with < / > at frame end.
  bit      m_res = 1'b0;
  longint  m_a = 0, m_b = 0;
  int      m_cnt = 0;
  bit      m_l = 1'b0, m_g = 1'b0, m_e = 1'b0, m_le = 1'b0;
  int      m_bc = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_res = 1'b0; m_a = 0; m_b = 0; m_cnt = 0;
      m_l = 1'b0; m_g = 1'b0; m_e = 1'b0; m_le = 1'b0; m_bc = 0;
    end else if (!m_res) begin
      if (bus.in_valid) begin
        m_a   = m_a * 2 + longint'(bus.a_bit);
        m_b   = m_b * 2 + longint'(bus.b_bit);
        m_cnt = m_cnt + 1;
        if (bus.in_last || m_cnt == N) begin
          m_res = 1'b1;
          m_l   = (m_a < m_b);
          m_g   = (m_a > m_b);
          m_e   = (m_a == m_b);
          m_le  = !(bus.in_last && m_cnt == N);
          m_bc  = m_cnt;
          m_a = 0; m_b = 0; m_cnt = 0;
        end
      end
    end else if (bus.res_ready) begin
      m_res = 1'b0;
      m_l = 1'b0; m_g = 1'b0; m_e = 1'b0; m_le = 1'b0; m_bc = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready",  int'(bus.in_ready),  int'(!m_res));
    chk("res_valid", int'(bus.res_valid), int'(m_res));
    chk("lesser",    int'(bus.lesser),    int'(m_l));
    chk("greater",   int'(bus.greater),   int'(m_g));
    chk("equal",     int'(bus.equal),     int'(m_e));
    chk("len_err",   int'(bus.len_err),   int'(m_le));
    chk("bit_count", int'(bus.bit_count), m_bc);
  end

  always @(posedge clk) begin
    #2;
    if (rr_rand) bus.res_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_accept();
    int t = 0;
    while (!bus.in_ready) begin
      tick();
      t++;
      if (t > 100) begin
        chk("accept_timeout", 0, 1);
        return;
      end
    end
    tick();
  endtask

  // Sends cnt beats of the w-bit operands, MSB first.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input int w,
                      input int cnt, input bit with_last, input bit gaps);
    for (int i = 0; i < cnt; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.a_bit    = a[w-1-i];
      bus.b_bit    = b[w-1-i];
      bus.in_last  = with_last && (i == cnt - 1);
      wait_accept();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_res(input string tag, input int l, input int g, input int e,
                         input int le, input int bc);
    chk({tag, "_res_valid"}, int'(bus.res_valid), 1);
    chk({tag, "_lesser"},    int'(bus.lesser),    l);
    chk({tag, "_greater"},   int'(bus.greater),   g);
    chk({tag, "_equal"},     int'(bus.equal),     e);
    chk({tag, "_len_err"},   int'(bus.len_err),   le);
    chk({tag, "_bit_count"}, int'(bus.bit_count), bc);
  endtask

  initial begin
    logic [31:0] x;
    int          len;
    bit          lst;

    bus.in_valid = 1'b0; bus.a_bit = 1'b0; bus.b_bit = 1'b0;
    bus.in_last = 1'b0; bus.res_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready",  int'(bus.in_ready), 1);
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_bit_count", int'(bus.bit_count), 0);
    rst = 1'b0;
    tick();

    // Equal full frame; verdict visible right after the final beat's edge.
    send(32'd2, 32'd2, 16, 16, 1'b1, 1'b0);
    chk_res("t_eq", 0, 0, 1, 0, 16);
    tick();
    chk("t_eq_back_ready", int'(bus.in_ready), 1);

    send(32'd44, 32'd444, 16, 16, 1'b1, 1'b0);
    chk_res("t_lt", 1, 0, 0, 0, 16);
    tick();

    // Stall: verdict held, beats offered meanwhile are not consumed.
    bus.res_ready = 1'b0;
    send(32'd8888, 32'd4545, 16, 16, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk_res("t_stall", 0, 1, 0, 0, 16);
      chk("t_stall_in_ready", int'(bus.in_ready), 0);
      bus.in_valid = 1'b1;
      bus.a_bit = 1'($urandom_range(0, 1));
      bus.b_bit = 1'($urandom_range(0, 1));
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t_stall_release_ready", int'(bus.in_ready), 1);
    chk("t_stall_release_greater", int'(bus.greater), 0);

    send(32'hAB, 32'hAC, 8, 8, 1'b1, 1'b0);
    chk_res("t_short", 1, 0, 0, 1, 8);
    tick();

    // Overlong stream: forced close at beat N, remainder forms a new frame.
    bus.res_ready = 1'b0;
    x = $urandom;
    send(x, x, 16, 16, 1'b0, 1'b0);
    chk_res("t_long1", 0, 0, 1, 1, 16);
    bus.res_ready = 1'b1;
    tick();
    send(32'd5, 32'd5, 3, 3, 1'b1, 1'b0);
    chk_res("t_long2", 0, 0, 1, 1, 3);
    tick();

    // Reset mid-frame discards the partial frame.
    send(32'd555, 32'd888, 16, 7, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t_rst_in_ready",  int'(bus.in_ready), 1);
    chk("t_rst_res_valid", int'(bus.res_valid), 0);
    send(32'd9999, 32'd9999, 16, 16, 1'b1, 1'b0);
    chk_res("t_rst_next", 0, 0, 1, 0, 16);
    tick();

    rr_rand = 1'b1;
    for (int f = 0; f < 150; f++) begin
      x = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        len = 16; lst = 1'b0;
      end else begin
        len = $urandom_range(1, 16); lst = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) send(x, x, len, len, lst, 1'b1);
      else                           send(x, $urandom, len, len, lst, 1'b1);
    end
    rr_rand = 1'b0;
    bus.res_ready = 1'b1;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
